// File: rtl/epp_host.sv
// Host-side initiator for the EPP-style parallel bus: turns single-byte commands
// into address/data write/read strobe cycles with a synchronised wait handshake.
module epp_host #(
  parameter int SETUP_CYCLES = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_write,
  input  logic       i_cmd_addr,
  input  logic [7:0] i_cmd_data,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_timeout,
  output logic       o_usb_write,
  output logic       o_usb_astb,
  output logic       o_usb_dstb,
  inout  wire  [7:0] io_usb_db,
  input  logic       i_usb_wait
);

  // state   | meaning
  // IDLE    | ready for a command
  // SETUP   | write/db held stable before the strobe
  // STROBE  | selected strobe low, waiting for wait_s high
  // RELEASE | strobes high, waiting for wait_s low
  // DONE    | one-cycle response, bus released
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int CW = (TW > SW) ? TW : SW;
  localparam logic [CW-1:0] C_SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST    = CW'(TIMEOUT - 1);

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_write_n, w_write_n;
  logic          r_astb, w_astb;
  logic          r_dstb, w_dstb;
  logic          r_oe, w_oe;
  logic [7:0]    r_db_out, w_db_out;
  logic          r_is_addr, w_is_addr;
  logic          r_is_write, w_is_write;
  logic          r_flag, w_flag;
  logic [7:0]    r_rsp_data, w_rsp_data;
  logic          r_wait_m, r_wait_s;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_write_n  <= 1'b1;
      r_astb     <= 1'b1;
      r_dstb     <= 1'b1;
      r_oe       <= 1'b0;
      r_db_out   <= 8'h00;
      r_is_addr  <= 1'b0;
      r_is_write <= 1'b0;
      r_flag     <= 1'b0;
      r_rsp_data <= 8'h00;
      r_wait_m   <= 1'b0;
      r_wait_s   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_write_n  <= w_write_n;
      r_astb     <= w_astb;
      r_dstb     <= w_dstb;
      r_oe       <= w_oe;
      r_db_out   <= w_db_out;
      r_is_addr  <= w_is_addr;
      r_is_write <= w_is_write;
      r_flag     <= w_flag;
      r_rsp_data <= w_rsp_data;
      r_wait_m   <= i_usb_wait;
      r_wait_s   <= r_wait_m;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_write_n  = r_write_n;
    w_astb     = r_astb;
    w_dstb     = r_dstb;
    w_oe       = r_oe;
    w_db_out   = r_db_out;
    w_is_addr  = r_is_addr;
    w_is_write = r_is_write;
    w_flag     = r_flag;
    w_rsp_data = r_rsp_data;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_is_write = i_cmd_write;
          w_is_addr  = i_cmd_addr;
          w_write_n  = ~i_cmd_write;
          w_oe       = i_cmd_write;
          w_db_out   = i_cmd_data;
          w_cnt      = C_SETUP_LAST;
          w_state    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          if (r_is_addr) w_astb = 1'b0;
          else           w_dstb = 1'b0;
          w_cnt   = '0;
          w_state = S_STROBE;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_STROBE: begin
        // a wait already high on entry counts as an immediate response
        if (r_wait_s) begin
          if (!r_is_write) w_rsp_data = io_usb_db;
          w_astb  = 1'b1;
          w_dstb  = 1'b1;
          w_cnt   = '0;
          w_state = S_RELEASE;
        end else if (r_cnt == C_TO_LAST) begin
          w_flag  = 1'b1;
          w_astb  = 1'b1;
          w_dstb  = 1'b1;
          w_state = S_RELEASE;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      S_RELEASE: begin
        if (!r_wait_s) begin
          w_state = S_DONE;
        end else if (r_cnt == C_TO_LAST) begin
          w_flag  = 1'b1;
          w_state = S_DONE;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      S_DONE: begin
        w_write_n = 1'b1;
        w_oe      = 1'b0;
        w_flag    = 1'b0;
        w_state   = S_IDLE;
      end
      default: begin
        w_astb    = 1'b1;
        w_dstb    = 1'b1;
        w_write_n = 1'b1;
        w_oe      = 1'b0;
        w_state   = S_IDLE;
      end
    endcase
  end

  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_rsp_valid   = (r_state == S_DONE);
  assign o_rsp_timeout = (r_state == S_DONE) && r_flag;
  assign o_rsp_data    = r_rsp_data;
  assign o_usb_write   = r_write_n;
  assign o_usb_astb    = r_astb;
  assign o_usb_dstb    = r_dstb;
  assign io_usb_db     = r_oe ? r_db_out : 8'bz;

endmodule

// File: tb/tb_epp_host.sv
// Bench for epp_host: fixed vectors, randomized cycles against a timing model,
// back-to-back and mid-cycle reset sequences, with a responder on the bus.
module tb_epp_host;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_write, cmd_addr;
  logic [7:0] cmd_data;
  logic       cmd_ready, rsp_valid, rsp_timeout;
  logic [7:0] rsp_data;
  logic       usb_write, usb_astb, usb_dstb, usb_wait;
  wire  [7:0] usb_db;
  logic [7:0] tb_drv;
  logic       tb_oe;

  int errs   = 0;
  int checks = 0;

  assign usb_db = tb_oe ? tb_drv : 8'bz;
  always #5 clk = ~clk;

  epp_host #(.SETUP_CYCLES(1), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_timeout(rsp_timeout),
    .o_usb_write(usb_write), .o_usb_astb(usb_astb), .o_usb_dstb(usb_dstb),
    .io_usb_db(usb_db), .i_usb_wait(usb_wait)
  );

  typedef struct {
    logic       wr;
    logic       ad;
    logic [7:0] data;
    logic       resp;
    int         d;
    int         dr;
    logic [7:0] rd;
    logic       exp_tmo;
    logic [7:0] exp_rdata;
    int         exp_low;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // host must not drive: the bench's own drive must come back unchanged
  task automatic bus_free(input string nm);
    tb_drv = 8'h00; tb_oe = 1'b1;
    #1 chk({nm, "_bus0"}, usb_db, 8'h00);
    tb_drv = 8'hFF;
    #1 chk({nm, "_busF"}, usb_db, 8'hFF);
    tb_oe = 1'b0;
  endtask

  task automatic run_cmd(input logic wr, input logic ad, input logic [7:0] data,
                         input logic resp, input int d, input int dr, input logic [7:0] rd,
                         output int n_valid, output logic tmo, output logic [7:0] rdata,
                         output int low, output logic wrong, output logic setup_ok);
    n_valid = 0; tmo = 1'b0; rdata = 8'h00; low = 0; wrong = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = ad; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    setup_ok = !cmd_ready && (usb_write == ~wr) && usb_astb && usb_dstb &&
               (!wr || usb_db == data);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (!(ad ? usb_astb : usb_dstb)) low++;
          if (!(ad ? usb_dstb : usb_astb)) wrong = 1'b1;
          if (rsp_valid) begin
            n_valid++;
            tmo   = rsp_timeout;
            rdata = rsp_data;
          end
        end
      end
      begin
        logic is_rd;
        int   k;
        if (resp) begin
          k = 0;
          while (k < 20 && (ad ? usb_astb : usb_dstb)) begin @(negedge clk); k++; end
          is_rd = usb_write;
          repeat (d) @(posedge clk);
          #1;
          usb_wait = 1'b1;
          if (is_rd) begin tb_drv = rd; tb_oe = 1'b1; end
          k = 0;
          while (k < 30 && !(ad ? usb_astb : usb_dstb)) begin @(negedge clk); k++; end
          repeat (dr) @(posedge clk);
          #1;
          usb_wait = 1'b0;
          tb_oe    = 1'b0;
        end
      end
    join
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int         nv, low, exp_low, k, idx, npulse, nrsp, rdy_low, nbad;
    logic       tmo, wrong, sok, prev_dstb, prev_rsp, exp_tmo;
    logic [7:0] rdat, model_rdata;
    logic [7:0] pulses[3];
    logic       r_wr, r_ad, r_resp;
    int         r_d, r_dr;
    logic [7:0] r_data, r_rd;

    vt[0] = '{1'b1, 1'b1, 8'h5A, 1'b1, 2, 1, 8'h00, 1'b0, 8'h00, 5};
    vt[1] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1, 0, 8'hC3, 1'b0, 8'hC3, 4};
    vt[2] = '{1'b1, 1'b0, 8'h11, 1'b0, 0, 0, 8'h00, 1'b1, 8'hC3, 8};
    vt[3] = '{1'b0, 1'b1, 8'h81, 1'b1, 5, 5, 8'h7E, 1'b0, 8'h7E, 8};
    vt[4] = '{1'b1, 1'b0, 8'h22, 1'b1, 0, 6, 8'h00, 1'b1, 8'h7E, 3};
    vt[5] = '{1'b0, 1'b1, 8'h66, 1'b0, 0, 0, 8'h99, 1'b1, 8'h7E, 8};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 1'b0; cmd_data = 8'h00;
    usb_wait = 1'b0; tb_oe = 1'b0; tb_drv = 8'h00;

    // reset state
    #3;
    chk("rst_astb", usb_astb, 1); chk("rst_dstb", usb_dstb, 1);
    chk("rst_write", usb_write, 1); chk("rst_rsp_valid", rsp_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1); chk("rst_rsp_valid2", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    bus_free("rst");

    // fixed vectors
    foreach (vt[i]) begin
      run_cmd(vt[i].wr, vt[i].ad, vt[i].data, vt[i].resp, vt[i].d, vt[i].dr, vt[i].rd,
              nv, tmo, rdat, low, wrong, sok);
      chk($sformatf("vec%0d_setup", i), sok, 1);
      chk($sformatf("vec%0d_nvalid", i), nv, 1);
      chk($sformatf("vec%0d_timeout", i), tmo, vt[i].exp_tmo);
      chk($sformatf("vec%0d_rdata", i), rdat, vt[i].exp_rdata);
      chk($sformatf("vec%0d_lowcycles", i), low, vt[i].exp_low);
      chk($sformatf("vec%0d_otherstrobe", i), wrong, 0);
    end

    // randomized cycles against the handshake timing model
    model_rdata = 8'h7E;
    for (int n = 0; n < 60; n++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_ad   = 1'($urandom_range(0, 1));
      r_resp = ($urandom_range(0, 3) != 0);
      r_d    = $urandom_range(0, TO - 3);
      r_dr   = $urandom_range(0, TO - 1);
      r_rd   = 8'($urandom);
      r_data = r_wr ? 8'($urandom) : ~r_rd;
      // wait seen after 2 sync flops + 1 edge; each phase bounded by TO cycles
      exp_low = r_resp ? r_d + 3 : TO;
      exp_tmo = !r_resp || (r_dr + 3 > TO);
      if (!r_wr && r_resp) model_rdata = r_rd;
      run_cmd(r_wr, r_ad, r_data, r_resp, r_d, r_dr, r_rd, nv, tmo, rdat, low, wrong, sok);
      chk($sformatf("rnd%0d_setup", n), sok, 1);
      chk($sformatf("rnd%0d_nvalid", n), nv, 1);
      chk($sformatf("rnd%0d_timeout", n), tmo, exp_tmo);
      chk($sformatf("rnd%0d_rdata", n), rdat, model_rdata);
      chk($sformatf("rnd%0d_lowcycles", n), low, exp_low);
      chk($sformatf("rnd%0d_otherstrobe", n), wrong, 0);
    end

    // back-to-back writes with cmd_valid held high, no responder
    @(posedge clk); #1;
    cmd_write = 1'b1; cmd_addr = 1'b0; cmd_data = 8'h01; cmd_valid = 1'b1;
    idx = 0; npulse = 0; nrsp = 0; rdy_low = 0; prev_dstb = 1'b1; prev_rsp = 1'b0;
    for (int c = 0; c < 120 && !(idx == 3 && nrsp == 3); c++) begin
      @(negedge clk);
      if (prev_rsp) chk("b2b_ready_after_done", cmd_ready, 1);
      if (prev_dstb && !usb_dstb) begin
        if (npulse < 3) pulses[npulse] = usb_db;
        npulse++;
      end
      if (!cmd_ready) rdy_low++;
      if (rsp_valid) nrsp++;
      prev_dstb = usb_dstb;
      prev_rsp  = rsp_valid;
      if (cmd_ready && cmd_valid) begin
        @(posedge clk); #1;
        idx++;
        if (idx == 3) cmd_valid = 1'b0;
        else          cmd_data  = 8'(idx + 1);
      end
    end
    chk("b2b_pulses", npulse, 3);
    chk("b2b_pulse0", pulses[0], 8'h01);
    chk("b2b_pulse1", pulses[1], 8'h02);
    chk("b2b_pulse2", pulses[2], 8'h03);
    chk("b2b_rsp_count", nrsp, 3);
    chk("b2b_ready_low_cycles", rdy_low, 33);
    cmd_valid = 1'b0;

    // reset while dstb is low
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 1'b0; cmd_data = 8'h81;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (usb_dstb && k < 20);
    chk("mid_dstb_low_seen", usb_dstb, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_dstb", usb_dstb, 1); chk("mid_astb", usb_astb, 1);
    chk("mid_write", usb_write, 1); chk("mid_rsp_valid", rsp_valid, 0);
    bus_free("mid");
    @(negedge clk);
    rst = 1'b0;
    nbad = 0;
    repeat (12) begin @(negedge clk); if (rsp_valid) nbad++; end
    chk("mid_no_rsp", nbad, 0);
    chk("mid_ready", cmd_ready, 1);
    run_cmd(1'b0, 1'b0, 8'hC3, 1'b1, 1, 1, 8'h3C, nv, tmo, rdat, low, wrong, sok);
    chk("post_setup", sok, 1);
    chk("post_nvalid", nv, 1);
    chk("post_timeout", tmo, 0);
    chk("post_rdata", rdat, 8'h3C);
    chk("post_lowcycles", low, 4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
